// File: rtl/sparse_sram_if.sv
// Request/response bundle for sparse_sram: one request in flight, one-cycle response pulse.
// Occupancy (count/full) travels with the bus so the requester can see table pressure.
interface sparse_sram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) ();
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic [DATA_W/8-1:0]          req_be;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_hit;
    logic                         rsp_err;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_hit, rsp_err, count, full
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_hit, rsp_err, count, full
    );
endinterface

// File: rtl/sparse_sram.sv
// Associative address/data table with ordered early-exit scan; hit at index k responds k+2 cycles after accept.
// No response backpressure: one request at a time, req_ready low from accept until the response cycle ends.
module sparse_sram #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] MISS_DATA = '0
) (
    input  logic          clk,
    input  logic          reset,
    sparse_sram_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t              r_state;
    logic                r_ready;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_idx;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_hit;
    logic                r_rsp_err;

    logic [ADDR_W-1:0]   r_tag  [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_alloc_idx;
    logic [CNT_W-1:0]    w_idx_nxt;
    logic                w_match;
    logic                w_last;
    logic                w_full;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_alloc_word;

    for (genvar b = 0; b < BE_W; b++) begin : g_mask
        assign w_mask[8*b +: 8] = {8{r_be[b]}};
    end

    assign w_idx        = r_idx[IDX_W-1:0];
    assign w_alloc_idx  = r_count[IDX_W-1:0];
    assign w_idx_nxt    = r_idx + CNT_W'(1);
    // Guarding on idx < count keeps stale tags beyond the occupied region from matching.
    assign w_match      = (r_idx < r_count) && (r_tag[w_idx] == r_addr);
    assign w_last       = (w_idx_nxt >= r_count);
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_merged     = (r_data[w_idx] & ~w_mask) | (r_wdata & w_mask);
    assign w_alloc_word = r_wdata & w_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_count     <= '0;
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_be    <= bus.req_be;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_match) begin
                        r_rsp_hit   <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                        if (r_we) begin
                            r_data[w_idx] <= w_merged;
                            r_rsp_rdata   <= w_merged;
                        end else begin
                            r_rsp_rdata   <= r_data[w_idx];
                        end
                    end else if (w_last) begin
                        r_rsp_hit   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                        if (!r_we) begin
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= MISS_DATA;
                        end else if (w_full) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= MISS_DATA;
                        end else begin
                            r_tag[w_alloc_idx]  <= r_addr;
                            r_data[w_alloc_idx] <= w_alloc_word;
                            r_count             <= r_count + CNT_W'(1);
                            r_rsp_err           <= 1'b0;
                            r_rsp_rdata         <= w_alloc_word;
                        end
                    end else begin
                        r_idx <= w_idx_nxt;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Ready is masked by reset so it reads low for the whole reset window and high right after.
    assign bus.req_ready = r_ready & ~reset;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
endmodule

// File: tb/tb_sparse_sram.sv
// Directed bench for sparse_sram (DEPTH=4): latency, hit/miss, byte merge, allocation, full and reset abort.
module tb_sparse_sram;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] MISS   = 32'h5A5A_5A5A;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    sparse_sram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    sparse_sram #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MISS_DATA(MISS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one request and check the full response; lat is the cycle of rsp_valid (accept edge = cycle 0).
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_hit, input logic exp_err,
                          input int exp_lat, input int exp_count);
        int n;
        int cyc;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check({tag, " ready_timeout"}, 0, 1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_addr  = 32'hFFFF_FFFF;
        cyc = 1;
        while (!bus.rsp_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.rsp_valid) begin
            check({tag, " rsp_timeout"}, 0, 1);
            return;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, " hit"}, bus.rsp_hit, exp_hit);
        check({tag, " err"}, bus.rsp_err, exp_err);
        check({tag, " count"}, bus.count, exp_count);
        check({tag, " full"}, bus.full, exp_count == DEPTH);
        check({tag, " ready_in_rsp"}, bus.req_ready, 0);
        @(negedge clk);
        check({tag, " pulse_end"}, bus.rsp_valid, 0);
        check({tag, " ready_after"}, bus.req_ready, 1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        repeat (3) @(negedge clk);
        check("rst ready", bus.req_ready, 0);
        check("rst count", bus.count, 0);
        check("rst full", bus.full, 0);
        check("rst rsp_valid", bus.rsp_valid, 0);
        check("rst hit", bus.rsp_hit, 0);
        check("rst err", bus.rsp_err, 0);
        check("rst rdata", bus.rsp_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst ready", bus.req_ready, 1);

        //      tag            we    addr      wdata         be       exp_rdata     hit err lat cnt
        do_req("rd_empty",    1'b0, 32'h100, 32'h0,        4'hF,    MISS,         0,  0,  2,  0);
        do_req("wr_alloc",    1'b1, 32'h100, 32'hDEADBEEF, 4'hF,    32'hDEADBEEF, 0,  0,  2,  1);
        do_req("rd_hit",      1'b0, 32'h100, 32'h0,        4'h0,    32'hDEADBEEF, 1,  0,  2,  1);
        do_req("wr_merge",    1'b1, 32'h100, 32'h11223344, 4'b0101, 32'hDE22BE44, 1,  0,  2,  1);
        do_req("rd_merged",   1'b0, 32'h100, 32'h0,        4'hF,    32'hDE22BE44, 1,  0,  2,  1);
        do_req("wr_partial",  1'b1, 32'h200, 32'hAABBCCDD, 4'b1000, 32'hAA000000, 0,  0,  2,  2);
        do_req("rd_partial",  1'b0, 32'h200, 32'h0,        4'hF,    32'hAA000000, 1,  0,  3,  2);

        apply_reset();
        check("rst2 count", bus.count, 0);
        do_req("fill0",       1'b1, 32'h0,   32'h1000,     4'hF,    32'h1000,     0,  0,  2,  1);
        do_req("fill4",       1'b1, 32'h4,   32'h1004,     4'hF,    32'h1004,     0,  0,  2,  2);
        do_req("fill8",       1'b1, 32'h8,   32'h1008,     4'hF,    32'h1008,     0,  0,  3,  3);
        do_req("fillC",       1'b1, 32'hC,   32'h100C,     4'hF,    32'h100C,     0,  0,  4,  4);
        do_req("rd_last",     1'b0, 32'hC,   32'h0,        4'hF,    32'h100C,     1,  0,  5,  4);
        do_req("rd_miss_full",1'b0, 32'h10,  32'h0,        4'hF,    MISS,         0,  0,  5,  4);
        do_req("wr_full",     1'b1, 32'h10,  32'h77777777, 4'hF,    MISS,         0,  1,  5,  4);
        do_req("rd_first",    1'b0, 32'h0,   32'h0,        4'hF,    32'h1000,     1,  0,  2,  4);

        // Abort a scan for index 3 partway through with reset.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'hC;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst ready_during", bus.req_ready, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst no_rsp", bus.rsp_valid, 0);
            check("midrst ready_low", bus.req_ready, 0);
        end
        check("midrst count", bus.count, 0);
        check("midrst full", bus.full, 0);
        check("midrst err", bus.rsp_err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst ready_after", bus.req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst stay_quiet", bus.rsp_valid, 0);
        end
        do_req("rd_after_rst",1'b0, 32'h0,   32'h0,        4'hF,    MISS,         0,  0,  2,  0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sparse_sram.md
# sparse_sram

Clocked, parametrised sparse memory model for the processor testbench data and instruction paths. It stores up to DEPTH address/data pairs in an associative table and services one read or write request at a time through a valid/ready handshake. Lookup is an ordered scan with early exit. It supports byte-enabled writes, allocation on write miss, and explicit miss and full reporting. It replaces the unclocked, fixed-size lookup model in testbench memories that need deterministic cycle timing.

## Interface
- DATA_W, 32, data word width; must be a multiple of 8
- ADDR_W, 32, address width
- DEPTH, 64, maximum number of stored entries (≥1)
- MISS_DATA, 0, DATA_W-bit value returned on a read miss
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address (exact-match key, no alignment)
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for a write; ignored on a read
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data, or the stored word after a write
- rsp_hit  out  1  address was already present
- rsp_err  out  1  write miss rejected because the table is full
- count  out  $clog2(DEPTH+1)  number of occupied entries
- full  out  1  count == DEPTH

## Operation
- Storage: tag[DEPTH], data[DEPTH]. Entries 0..count-1 are occupied and contiguous. There is no delete.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: req_ready=1. When req_valid, latch we/addr/wdata/be, set idx=0, go to SCAN.
  - SCAN: compare tag[idx] with the latched address, only if idx < count.
    - Match: hit=1, go to RESP.
    - Else if idx+1 ≥ count, including count==0: miss, go to RESP.
    - Else idx+1.
  - RESP: rsp_valid=1, req_ready=0, next state is IDLE.
- Responses, registered on entry to RESP:
  - Read hit: rdata=data[idx], hit=1.
  - Read miss: rdata=MISS_DATA, hit=0, err=0.
  - Write hit: data[idx] = (old & ~mask) | (wdata & mask), where mask expands req_be per byte. rdata returns the merged word, hit=1.
  - Write miss, not full: tag[count]=addr, data[count]=wdata & mask (unenabled bytes zero), count+1. rdata returns that word, hit=0.
  - Write miss, full: no state change, err=1, hit=0, rdata=MISS_DATA.
- Duplicate tags never occur, so at most one entry matches.
- rsp_hit, rsp_err and rsp_rdata are valid only while rsp_valid=1. They hold their last value otherwise.

## Timing
- Reset values: state=IDLE, count=0, full=0, rsp_valid=0, rsp_hit=0, rsp_err=0, rsp_rdata=0, req_ready=0 while reset is high. req_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation aborts the request with no response. Table contents are logically discarded (count=0); clearing the data arrays is not required.
- Cycle numbering: acceptance edge = cycle 0. SCAN occupies cycles 1..k+1 for a hit at index k. rsp_valid is high in cycle k+2.
- Miss latency: rsp_valid in cycle max(count,1)+1.
- The next request is accepted at the earliest in the cycle after rsp_valid. Throughput is at most one request per latency+1 cycles.
- count and full update in the same cycle rsp_valid rises.
- There is no response backpressure. The rsp_valid pulse is exactly one cycle.
- req_valid while req_ready=0 is ignored. Inputs are not sampled outside IDLE.

## Test plan
- **Reset, then read on empty table:** read 0x100 -> rsp_valid in cycle 2, rsp_hit=0, rsp_rdata=MISS_DATA, count=0.
- **Allocate then read:**
  - Write 0x100=0xDEADBEEF, be=0xF -> rsp_hit=0, count=1.
  - Read 0x100 -> rsp_hit=1, rdata=0xDEADBEEF, rsp_valid in cycle 2.
- **Byte-merge on hit:** after the previous step, write 0x100=0x11223344 with be=0b0101 -> rdata=0xDE22BE44. A subsequent read returns the same value.
- **Partial write miss:** write 0x200=0xAABBCCDD, be=0b1000 -> stored value 0xAA000000, count increments.
- **Scan latency and full table:**
  - Fill DEPTH=4 with addresses 0,4,8,C.
  - Read C -> rsp_valid in cycle 5.
  - Read 0x10 -> miss in cycle 5.
  - Write 0x10 -> rsp_err=1, full=1, count stays 4.
- **Reset mid-scan:**
  - Assert reset during SCAN -> no rsp_valid, count=0, req_ready=0 during reset and 1 the cycle after.
  - A later read of a previously written address -> miss.
